usb_stream_router: RTL and testbench
====================================

USB_STREAM_ROUTER -- requirements
Module: usb_stream_router

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, header sync byte.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  permits the start of new frames.
REQ-005 SHALL have port rx_data  input  32  USB receive stream word.
REQ-006 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-007 SHALL have port rx_ready  output  1  word accepted when rx_valid and rx_ready are both high.
REQ-008 SHALL have port cha_data  output  32  payload to DAC channel A (drives usb_rd_data).
REQ-009 SHALL have port cha_valid  output  1  write strobe to channel A (drives usb_rd_data_valid).
REQ-010 SHALL have port cha_full  input  1  channel A FIFO full (from usb_rd_full).
REQ-011 SHALL have ports chb_data, chb_valid and chb_full; these are identical to the channel A ports, for channel B.
REQ-012 SHALL have port frames_ok  output  16  count of completed frames.
REQ-013 SHALL have port sync_err  output  16  count of bad header words.
REQ-014 SHALL have port chan_err  output  16  count of frames addressed to an invalid channel.
REQ-015 SHALL have port busy  output  1  high when state is not HUNT.

Function
REQ-016 Header word format SHALL be: [31:24] sync; [23:16] channel ID (0=A, 1=B); [15:0] payload length N in words.
REQ-017 The FSM SHALL have three states: HUNT, PAYLOAD and DROP.
REQ-018 In HUNT, rx_ready SHALL equal enable; with enable low, no word SHALL be consumed.
REQ-019 In HUNT, an accepted word whose sync field is not SYNC SHALL increment sync_err and leave the state in HUNT.
REQ-020 Valid header, channel ID 0 or 1, N>0: the FSM SHALL latch the channel and load the remain counter with N, then go to PAYLOAD.
REQ-021 Valid header, channel ID 0 or 1, N=0: frames_ok SHALL increment and the state SHALL stay in HUNT.
REQ-022 Valid header, channel ID >1, N>0: chan_err SHALL increment, remain SHALL load N, and the state SHALL go to DROP.
REQ-023 Valid header, channel ID >1, N=0: chan_err SHALL increment and the state SHALL stay in HUNT.
REQ-024 In PAYLOAD, rx_ready SHALL equal the inverse of the selected channel's full input.
REQ-025 In DROP, rx_ready SHALL be 1 and accepted words SHALL be discarded.
REQ-026 In PAYLOAD, the selected channel's data output SHALL equal rx_data and its valid SHALL be rx_valid AND rx_ready, combinationally (zero latency).
REQ-027 The unselected channel's valid SHALL be 0; all valid outputs SHALL be 0 outside PAYLOAD.
REQ-028 The data outputs SHALL always carry rx_data.
REQ-029 Each payload or drop word accepted SHALL decrement remain by 1.
REQ-030 On acceptance with remain==1: the state SHALL go to HUNT; from PAYLOAD, frames_ok SHALL also increment.
REQ-031 enable SHALL be ignored outside HUNT; a frame in progress always completes.
REQ-032 The full input SHALL be sampled combinationally; no write SHALL be issued in a cycle where the selected full input is high.
REQ-033 All counters SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-034 Payload words SHALL NOT be checked for sync.

Reset
REQ-035 On reset, the state SHALL go to HUNT and remain, frames_ok, sync_err, chan_err and busy SHALL all go to 0.
REQ-036 Reset mid-frame SHALL abandon the frame; the first accepted word after reset SHALL be treated as a header.
REQ-037 During reset, rx_ready SHALL be 0 and cha_valid and chb_valid SHALL be 0.

Structure
REQ-038 Package usb_stream_pkg SHALL hold the SYNC default, the state enum, the header field bit positions and the channel ID constants.
REQ-039 A sub-module sat_counter SHALL be used, three instances: 16-bit, with reset and increment inputs, saturating.
REQ-040 The FSM and the remain counter SHALL stay inline in usb_stream_router.

Verification
REQ-041 Header A5_00_0003 then words 11,22,33, cha_full=0 -> cha_valid high for 3 cycles with data 11,22,33; chb_valid stays 0; frames_ok=1.
REQ-042 Header A5_01_0004; chb_full high for 2 cycles after the 2nd word -> rx_ready low for those 2 cycles; exactly 4 chb writes, none while full.
REQ-043 Words 12345678 then A5_00_0000 -> sync_err=1 then frames_ok=1; no channel writes.
REQ-044 Header A5_07_0002 plus 2 words, then A5_00_0001 plus 1 word -> chan_err=1; exactly 1 cha write with the final word.
REQ-045 Reset asserted after the 1st of 3 payload words, next word A5_01_0001 -> that word is parsed as a header; busy=1; all counters 0.
REQ-046 Force 65536 bad sync words -> sync_err holds at FFFF; enable=0 in HUNT -> rx_ready=0 and no words consumed.

Source files
------------

// File: rtl/usb_stream_router_pkg.sv
// Shared definitions for the USB stream router: sync default, FSM states,
// header field positions, channel IDs and header field helpers.
package usb_stream_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Header word layout: [31:24] sync, [23:16] channel ID, [15:0] length
  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 24;
  localparam int CHAN_MSB = 23;
  localparam int CHAN_LSB = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  localparam logic [7:0] CHAN_A = 8'd0;
  localparam logic [7:0] CHAN_B = 8'd1;

  function automatic logic [7:0] hdr_sync(input logic [31:0] word);
    return word[SYNC_MSB:SYNC_LSB];
  endfunction

  function automatic logic [7:0] hdr_chan(input logic [31:0] word);
    return word[CHAN_MSB:CHAN_LSB];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [31:0] word);
    return word[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/usb_stream_router_if.sv
// Stream bundle between the USB receive side and the two DAC channel FIFOs.
// The master drives the receive stream and the FIFO full flags; the slave
// (the router) answers with rx_ready and the channel write strobes.
interface usb_stream_router_if;

  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic [31:0] cha_data;
  logic        cha_valid;
  logic        cha_full;

  logic [31:0] chb_data;
  logic        chb_valid;
  logic        chb_full;

  modport master (
    output rx_data, rx_valid, cha_full, chb_full,
    input  rx_ready, cha_data, cha_valid, chb_data, chb_valid
  );

  modport slave (
    input  rx_data, rx_valid, cha_full, chb_full,
    output rx_ready, cha_data, cha_valid, chb_data, chb_valid
  );

endinterface

// File: rtl/usb_stream_router_sat_counter.sv
// Saturating event counter: counts increment pulses, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc unless already at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/usb_stream_router.sv
// USB stream router: parses framed 32-bit words (header + N payload words)
// and steers payloads to DAC channel A or B with zero-latency handshaking.
// Frames for unknown channels are drained; bad headers are counted.
module usb_stream_router
  import usb_stream_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  usb_stream_router_if.slave   bus,
  output logic [15:0]          frames_ok,
  output logic [15:0]          sync_err,
  output logic [15:0]          chan_err,
  output logic                 busy
);

  state_t      state_r;
  logic [15:0] remain_r;
  logic        chan_r;        // 0 = channel A, 1 = channel B

  logic        ready_s;
  logic        accept_s;
  logic        sel_full_s;
  logic        sync_ok_s;
  logic        chan_ok_s;
  logic [15:0] len_s;
  logic        last_s;
  logic        frame_inc_s;
  logic        sync_inc_s;
  logic        chan_inc_s;

  // Header field decode of the current receive word
  always_comb begin
    sync_ok_s = (hdr_sync(bus.rx_data) == SYNC);
    chan_ok_s = (hdr_chan(bus.rx_data) == CHAN_A) || (hdr_chan(bus.rx_data) == CHAN_B);
    len_s     = hdr_len(bus.rx_data);
    last_s    = (remain_r == 16'd1);
  end

  // Backpressure toward the USB side depends on the current state
  always_comb begin
    ready_s    = 1'b0;
    sel_full_s = chan_r ? bus.chb_full : bus.cha_full;
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_HUNT:    ready_s = enable;
        ST_PAYLOAD: ready_s = ~sel_full_s;
        ST_DROP:    ready_s = 1'b1;
        default:    ready_s = 1'b0;
      endcase
    end
  end

  // Zero-latency write strobes; data lines always mirror the receive word
  always_comb begin
    accept_s      = bus.rx_valid && ready_s;
    bus.rx_ready  = ready_s;
    bus.cha_data  = bus.rx_data;
    bus.chb_data  = bus.rx_data;
    if (state_r == ST_PAYLOAD) begin
      bus.cha_valid = accept_s && !chan_r;
      bus.chb_valid = accept_s && chan_r;
    end else begin
      bus.cha_valid = 1'b0;
      bus.chb_valid = 1'b0;
    end
  end

  // Event pulses feeding the statistics counters
  always_comb begin
    frame_inc_s = 1'b0;
    sync_inc_s  = 1'b0;
    chan_inc_s  = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_HUNT: begin
          sync_inc_s  = !sync_ok_s;
          chan_inc_s  = sync_ok_s && !chan_ok_s;
          frame_inc_s = sync_ok_s && chan_ok_s && (len_s == 16'd0);
        end
        ST_PAYLOAD: frame_inc_s = last_s;
        ST_DROP:    frame_inc_s = 1'b0;
        default:    frame_inc_s = 1'b0;
      endcase
    end else begin
      frame_inc_s = 1'b0;
    end
  end

  // Frame FSM with the remaining-word counter and latched channel
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_HUNT;
      remain_r <= 16'd0;
      chan_r   <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_HUNT: begin
          if (sync_ok_s && (len_s != 16'd0)) begin
            remain_r <= len_s;
            if (chan_ok_s) begin
              state_r <= ST_PAYLOAD;
              chan_r  <= (hdr_chan(bus.rx_data) == CHAN_B);
            end else begin
              state_r <= ST_DROP;
            end
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_PAYLOAD, ST_DROP: begin
          remain_r <= remain_r - 16'd1;
          if (last_s) begin
            state_r <= ST_HUNT;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r  <= ST_HUNT;
          remain_r <= 16'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign busy = (state_r != ST_HUNT);

  sat_counter #(.WIDTH(16)) u_frames_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_inc_s),
    .count (frames_ok)
  );

  sat_counter #(.WIDTH(16)) u_sync_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sync_inc_s),
    .count (sync_err)
  );

  sat_counter #(.WIDTH(16)) u_chan_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (chan_inc_s),
    .count (chan_err)
  );

endmodule

// File: tb/tb_usb_stream_router.sv
// Self-checking bench for usb_stream_router: a directed vector table, hand
// sequences for multi-cycle corners and a randomized run, all compared
// against a frame-level reference model kept in the bench.
module tb_usb_stream_router;
  import usb_stream_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] frames_ok;
  logic [15:0] sync_err;
  logic [15:0] chan_err;
  logic        busy;

  usb_stream_router_if bus();

  usb_stream_router #(.SYNC(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .frames_ok (frames_ok),
    .sync_err  (sync_err),
    .chan_err  (chan_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: where we are in the frame, expressed as words to go
  int m_mode = 0;          // 0 waiting for header, 1 delivering, 2 discarding
  int m_left = 0;
  int m_chan = 0;
  int m_frames = 0;
  int m_sync = 0;
  int m_chanerr = 0;

  int cha_writes = 0;
  int chb_writes = 0;
  logic [31:0] last_cha = 32'd0;
  logic s_ready, s_a, s_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x < 65535) ? x + 1 : 65535;
  endfunction

  task automatic model_accept(input logic [31:0] w);
    int ch, n;
    if (m_mode == 0) begin
      ch = int'(w[23:16]);
      n  = int'(w[15:0]);
      if (w[31:24] != 8'hA5) m_sync = sat_inc(m_sync);
      else if (ch > 1) begin
        m_chanerr = sat_inc(m_chanerr);
        if (n > 0) begin m_mode = 2; m_left = n; end
      end else if (n == 0) m_frames = sat_inc(m_frames);
      else begin m_mode = 1; m_left = n; m_chan = ch; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 1) m_frames = sat_inc(m_frames);
        m_mode = 0;
      end
    end
  endtask

  // One clock cycle: drive, check combinational and registered outputs, advance model
  task automatic step(input logic [31:0] d, input logic v, input logic fa,
                      input logic fb, input logic en, input logic rst);
    logic exp_ready, acc;
    bus.rx_data  = d;
    bus.rx_valid = v;
    bus.cha_full = fa;
    bus.chb_full = fb;
    enable       = en;
    reset        = rst;
    @(negedge clk);
    if (rst) exp_ready = 1'b0;
    else if (m_mode == 0) exp_ready = en;
    else if (m_mode == 1) exp_ready = (m_chan == 1) ? !fb : !fa;
    else exp_ready = 1'b1;
    acc = v && exp_ready;
    s_ready = bus.rx_ready;
    s_a = bus.cha_valid;
    s_b = bus.chb_valid;
    chk("rx_ready", {31'd0, bus.rx_ready}, {31'd0, exp_ready});
    chk("cha_valid", {31'd0, bus.cha_valid}, {31'd0, acc && m_mode == 1 && m_chan == 0});
    chk("chb_valid", {31'd0, bus.chb_valid}, {31'd0, acc && m_mode == 1 && m_chan == 1});
    chk("cha_data", bus.cha_data, d);
    chk("chb_data", bus.chb_data, d);
    chk("frames_ok", {16'd0, frames_ok}, m_frames);
    chk("sync_err", {16'd0, sync_err}, m_sync);
    chk("chan_err", {16'd0, chan_err}, m_chanerr);
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    if (bus.cha_valid) begin cha_writes++; last_cha = bus.cha_data; end
    if (bus.chb_valid) chb_writes++;
    if (rst) begin
      m_mode = 0; m_left = 0; m_chan = 0;
      m_frames = 0; m_sync = 0; m_chanerr = 0;
    end else if (acc) model_accept(d);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic valid, fa, fb;
    logic exp_ready, exp_a, exp_b;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int base_a, base_b, base_ce, base_fr;
    logic [31:0] rd;

    tbl[0]  = '{32'hA500_0003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h0000_0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_0033, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{32'hA501_0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_0003, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    step(32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_frames", {16'd0, frames_ok}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Directed table: channel A frame, then channel B frame with backpressure
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].data, tbl[i].valid, tbl[i].fa, tbl[i].fb, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_cha", i), {31'd0, s_a}, {31'd0, tbl[i].exp_a});
      chk($sformatf("tbl%0d_chb", i), {31'd0, s_b}, {31'd0, tbl[i].exp_b});
    end
    chk("tbl_frames_ok", {16'd0, frames_ok}, 32'd2);
    chk("tbl_cha_writes", cha_writes, 32'd3);
    chk("tbl_chb_writes", chb_writes, 32'd4);

    // Bad sync then zero-length frame
    base_a = cha_writes; base_b = chb_writes;
    step(32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("badsync_err", {16'd0, sync_err}, 32'd1);
    step(32'hA500_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("zero_len_frames", {16'd0, frames_ok}, 32'd3);
    chk("zero_len_writes", cha_writes + chb_writes, base_a + base_b);

    // Invalid channel frame drained, then a one-word channel A frame
    base_a = cha_writes; base_b = chb_writes; base_ce = int'(chan_err);
    step(32'hA507_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'hAAAA_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hA500_0009, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hA500_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop_chan_err", {16'd0, chan_err}, base_ce + 1);
    chk("drop_cha_writes", cha_writes, base_a + 1);
    chk("drop_chb_writes", chb_writes, base_b);
    chk("drop_last_data", last_cha, 32'hCAFE_F00D);

    // Reset mid-frame: next word is a header again
    step(32'hA500_0003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_ready_low", {31'd0, s_ready}, 32'd0);
    chk("rst_valid_low", {30'd0, s_a, s_b}, 32'd0);
    step(32'hA501_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_hdr_busy", {31'd0, busy}, 32'd1);
    chk("rst_counters", {frames_ok | sync_err | chan_err, 16'd0}, 32'd0);
    base_fr = int'(frames_ok);
    step(32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_frame_done", {16'd0, frames_ok}, base_fr + 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0)
        rd = {8'hA5, 8'($urandom_range(0, 3)), 16'($urandom_range(0, 4))};
      else
        rd = $urandom;
      step(rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 299) == 0));
    end

    // Saturation of sync_err
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) step(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sync_err_sat", {16'd0, sync_err}, 32'h0000_FFFF);

    // enable low in HUNT: nothing consumed
    for (int i = 0; i < 3; i++) begin
      step(32'hA500_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("disabled_ready", {31'd0, s_ready}, 32'd0);
    end
    chk("disabled_frames", {16'd0, frames_ok}, 32'd0);
    chk("disabled_sync", {16'd0, sync_err}, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
